// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage. It holds the EXE/MEM register, a
//               word-addressed data RAM and the MEM/WB register. Loads read
//               the RAM combinationally during the MEM cycle. A store writes
//               on the edge where it leaves MEM. The MEM-cycle result and
//               destination are also exported for operand forwarding.
// Ports       : clk, reset (async, active-high; clears pipeline registers)
//               stall (hold both registers, block RAM write)
//               flush (bubble into EXE/MEM)
//               valid_EXE, AluResult_EXE, storeData_EXE, rd_EXE,
//               signals_EXE = {MemRd, MemWr, WBsrc, RegWr}
//               AluResult_MEM, rd_MEM, RegWr_MEM   -> forwarding unit
//               WBValue_WB, rd_WB, RegWr_WB, valid_WB -> write-back
// Config      : MEM_STAGE_ADDR_CHECK_EN adds addr_err_WB. A valid load or
//               store with nonzero address bits above ADDR_W is flagged. The
//               store is dropped and the load returns 0. Without the macro
//               those upper bits are ignored and the address wraps.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_EXE,
    input  logic [DATA_W-1:0] AluResult_EXE,
    input  logic [DATA_W-1:0] storeData_EXE,
    input  logic [2:0]        rd_EXE,
    input  logic [3:0]        signals_EXE,
    output logic [DATA_W-1:0] AluResult_MEM,
    output logic [2:0]        rd_MEM,
    output logic              RegWr_MEM,
    output logic [DATA_W-1:0] WBValue_WB,
    output logic [2:0]        rd_WB,
    output logic              RegWr_WB,
`ifdef MEM_STAGE_ADDR_CHECK_EN
    output logic              addr_err_WB,
`endif
    output logic              valid_WB
);

    localparam int c_DEPTH = 1 << ADDR_W;

    // EXE/MEM register
    logic              valid_mem_q, valid_mem_d;
    logic [DATA_W-1:0] alu_mem_q,   alu_mem_d;
    logic [DATA_W-1:0] store_mem_q, store_mem_d;
    logic [2:0]        rd_mem_q,    rd_mem_d;
    logic [3:0]        sig_mem_q,   sig_mem_d;

    // MEM/WB register
    logic              valid_wb_q,  valid_wb_d;
    logic [DATA_W-1:0] wbval_wb_q,  wbval_wb_d;
    logic [2:0]        rd_wb_q,     rd_wb_d;
    logic              regwr_wb_q,  regwr_wb_d;
`ifdef MEM_STAGE_ADDR_CHECK_EN
    logic              addr_err_q,  addr_err_d;
`endif

    // Data RAM (not reset)
    logic [DATA_W-1:0] ram_q [0:c_DEPTH-1];

    logic              w_mem_rd;
    logic              w_mem_wr;
    logic              w_wb_src;
    logic              w_reg_wr;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_rdata;
    logic [DATA_W-1:0] w_load_word;
    logic [DATA_W-1:0] w_wb_value;
    logic              w_addr_err;
    logic              w_ram_we;

    // ------------------------------------------------------------------
    // EXE/MEM next state. A stall takes priority over a flush, so a
    // flush during a stall is lost (upstream holds it until release).
    // ------------------------------------------------------------------
    always_comb begin
        valid_mem_d = valid_mem_q;
        alu_mem_d   = alu_mem_q;
        store_mem_d = store_mem_q;
        rd_mem_d    = rd_mem_q;
        sig_mem_d   = sig_mem_q;
        if (!stall) begin
            if (flush) begin
                valid_mem_d = 1'b0;
                alu_mem_d   = '0;
                store_mem_d = '0;
                rd_mem_d    = '0;
                sig_mem_d   = '0;
            end else begin
                valid_mem_d = valid_EXE;
                alu_mem_d   = AluResult_EXE;
                store_mem_d = storeData_EXE;
                rd_mem_d    = rd_EXE;
                sig_mem_d   = signals_EXE;
            end
        end
    end

    // ------------------------------------------------------------------
    // MEM-cycle datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_mem_rd    = sig_mem_q[3];
        w_mem_wr    = sig_mem_q[2];
        w_wb_src    = sig_mem_q[1];
        w_reg_wr    = sig_mem_q[0];
        w_ram_addr  = alu_mem_q[ADDR_W-1:0];
        w_ram_rdata = ram_q[w_ram_addr];
`ifdef MEM_STAGE_ADDR_CHECK_EN
        w_addr_err  = valid_mem_q & (w_mem_rd | w_mem_wr)
                      & (|alu_mem_q[DATA_W-1:ADDR_W]);
`else
        w_addr_err  = 1'b0;
`endif
        // The write happens only on the edge that moves the store out of
        // MEM. This gives exactly one write however long the store stalls.
        // The reset term drops a store whose edge meets reset assertion.
        w_ram_we    = valid_mem_q & w_mem_wr & ~stall & ~reset & ~w_addr_err;
        // When MemRd and MemWr are both set, the instruction is a store.
        // Only a pure load returns RAM data. Anything else returns 0.
        w_load_word = (w_mem_rd & ~w_mem_wr & ~w_addr_err) ? w_ram_rdata : '0;
        w_wb_value  = (w_wb_src & ~w_mem_wr) ? w_load_word : alu_mem_q;
    end

    // ------------------------------------------------------------------
    // MEM/WB next state. A bubble in MEM produces an all-zero WB slot.
    // ------------------------------------------------------------------
    always_comb begin
        valid_wb_d = valid_wb_q;
        wbval_wb_d = wbval_wb_q;
        rd_wb_d    = rd_wb_q;
        regwr_wb_d = regwr_wb_q;
`ifdef MEM_STAGE_ADDR_CHECK_EN
        addr_err_d = addr_err_q;
`endif
        if (!stall) begin
            if (valid_mem_q) begin
                valid_wb_d = 1'b1;
                wbval_wb_d = w_wb_value;
                rd_wb_d    = rd_mem_q;
                regwr_wb_d = w_reg_wr;
            end else begin
                valid_wb_d = 1'b0;
                wbval_wb_d = '0;
                rd_wb_d    = '0;
                regwr_wb_d = 1'b0;
            end
`ifdef MEM_STAGE_ADDR_CHECK_EN
            addr_err_d = w_addr_err;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_mem_q <= 1'b0;
            alu_mem_q   <= '0;
            store_mem_q <= '0;
            rd_mem_q    <= '0;
            sig_mem_q   <= '0;
            valid_wb_q  <= 1'b0;
            wbval_wb_q  <= '0;
            rd_wb_q     <= '0;
            regwr_wb_q  <= 1'b0;
`ifdef MEM_STAGE_ADDR_CHECK_EN
            addr_err_q  <= 1'b0;
`endif
        end else begin
            valid_mem_q <= valid_mem_d;
            alu_mem_q   <= alu_mem_d;
            store_mem_q <= store_mem_d;
            rd_mem_q    <= rd_mem_d;
            sig_mem_q   <= sig_mem_d;
            valid_wb_q  <= valid_wb_d;
            wbval_wb_q  <= wbval_wb_d;
            rd_wb_q     <= rd_wb_d;
            regwr_wb_q  <= regwr_wb_d;
`ifdef MEM_STAGE_ADDR_CHECK_EN
            addr_err_q  <= addr_err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            ram_q[w_ram_addr] <= store_mem_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign AluResult_MEM = alu_mem_q;
    assign rd_MEM        = rd_mem_q;
    assign RegWr_MEM     = valid_mem_q & w_reg_wr;
    assign WBValue_WB    = wbval_wb_q;
    assign rd_WB         = rd_wb_q;
    assign RegWr_WB      = regwr_wb_q;
    assign valid_WB      = valid_wb_q;
`ifdef MEM_STAGE_ADDR_CHECK_EN
    assign addr_err_WB   = addr_err_q;
`endif

endmodule
`default_nettype wire
